// File: rtl/msx_core_switch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | msx_core_switch : selects one of up to four MSX cores at runtime, with  |
// | drain-to-vblank, reset hold and optional VRAM clear on every change.    |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module msx_core_switch #(
   parameter int NUM_CORES     = 2,
   parameter int VRAM_BANKS    = 2,
   parameter int VRAM_AW       = 16,
   parameter int HOLD_CYCLES   = 1024,
   parameter int DRAIN_TIMEOUT = 430000,
   parameter int CLEAR_VRAM    = 1
) (
   input  logic                            clk21m,
   input  logic                            reset_n,
   input  logic [1:0]                      typ_req,
   input  logic                            soft_reset,
   input  logic                            wr_n,
   output logic [NUM_CORES-1:0]            core_wr_n,
   output logic [NUM_CORES-1:0]            core_reset,
   input  logic [8*NUM_CORES-1:0]          core_d_to_cpu,
   input  logic [NUM_CORES-1:0]            core_busrq,
   input  logic [24*NUM_CORES-1:0]         core_rgb,
   input  logic [6*NUM_CORES-1:0]          core_sync,
   input  logic [8*NUM_CORES-1:0]          core_ram_bank,
   input  logic [VRAM_AW*NUM_CORES-1:0]    core_vram_addr,
   input  logic [8*NUM_CORES-1:0]          core_vram_do,
   input  logic [VRAM_BANKS*NUM_CORES-1:0] core_vram_we,
   output logic [7:0]                      d_to_cpu,
   output logic                            dataBusRQ,
   output logic [7:0]                      R,
   output logic [7:0]                      G,
   output logic [7:0]                      B,
   output logic                            HS,
   output logic                            VS,
   output logic                            DE,
   output logic                            hblank,
   output logic                            vblank,
   output logic                            vdp_int_n,
   output logic [7:0]                      ram_bank,
   output logic [VRAM_AW-1:0]              vram_addr,
   output logic [7:0]                      vram_do,
   output logic [VRAM_BANKS-1:0]           vram_we,
   output logic [1:0]                      active,
   output logic                            busy
);

   localparam int c_vram_depth = 1 << VRAM_AW;
   localparam int c_max_a      = (DRAIN_TIMEOUT > HOLD_CYCLES) ? DRAIN_TIMEOUT : HOLD_CYCLES;
   localparam int c_max        = (c_max_a > c_vram_depth) ? c_max_a : c_vram_depth;
   localparam int c_cnt_w      = $clog2(c_max + 1);

   localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DRAIN_TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(HOLD_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_clear_last = c_cnt_w'(c_vram_depth - 1);
   localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   state_t               state_q;
   logic [1:0]           active_q;
   logic [1:0]           target_q;
   logic [c_cnt_w-1:0]   cnt_q;
   logic                 vblank_q;

   // Per-core views padded to four entries so a 2-bit index is always in range.
   logic [7:0]            w_d_arr     [4];
   logic                  w_busrq_arr [4];
   logic [23:0]           w_rgb_arr   [4];
   logic [5:0]            w_sync_arr  [4];
   logic [7:0]            w_bank_arr  [4];
   logic [VRAM_AW-1:0]    w_vaddr_arr [4];
   logic [7:0]            w_vdo_arr   [4];
   logic [VRAM_BANKS-1:0] w_vwe_arr   [4];

   for (genvar i = 0; i < 4; i++) begin : g_unpack
      if (i < NUM_CORES) begin : g_core
         assign w_d_arr[i]     = core_d_to_cpu[8*i +: 8];
         assign w_busrq_arr[i] = core_busrq[i];
         assign w_rgb_arr[i]   = core_rgb[24*i +: 24];
         assign w_sync_arr[i]  = core_sync[6*i +: 6];
         assign w_bank_arr[i]  = core_ram_bank[8*i +: 8];
         assign w_vaddr_arr[i] = core_vram_addr[VRAM_AW*i +: VRAM_AW];
         assign w_vdo_arr[i]   = core_vram_do[8*i +: 8];
         assign w_vwe_arr[i]   = core_vram_we[VRAM_BANKS*i +: VRAM_BANKS];
      end else begin : g_pad
         assign w_d_arr[i]     = '0;
         assign w_busrq_arr[i] = 1'b0;
         assign w_rgb_arr[i]   = '0;
         assign w_sync_arr[i]  = '0;
         assign w_bank_arr[i]  = '0;
         assign w_vaddr_arr[i] = '0;
         assign w_vdo_arr[i]   = '0;
         assign w_vwe_arr[i]   = '0;
      end
   end

   logic [5:0]            w_sel_sync;
   logic                  w_run;
   logic                  w_clear;
   logic                  w_req_valid;
   logic                  w_vb_rise;
   logic [NUM_CORES-1:0]  w_mine;

   assign w_sel_sync  = w_sync_arr[active_q];
   assign w_run       = (state_q == ST_RUN);
   assign w_clear     = (state_q == ST_CLEAR);
   assign w_req_valid = ({30'd0, typ_req} < 32'(NUM_CORES));
   assign w_vb_rise   = w_sel_sync[1] & ~vblank_q;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_gate
      assign w_mine[i]     = w_run && (active_q == 2'(i));
      assign core_reset[i] = ~w_mine[i];
      assign core_wr_n[i]  = w_mine[i] ? wr_n : 1'b1;
   end

   // Sync bit order within a core: {HS, VS, DE, hblank, vblank, int_n}.
   assign d_to_cpu  = w_run ? w_d_arr[active_q] : 8'hFF;
   assign dataBusRQ = w_run & w_busrq_arr[active_q];
   assign {R, G, B} = w_run ? w_rgb_arr[active_q] : 24'h0;
   assign HS        = w_sel_sync[5];
   assign VS        = w_sel_sync[4];
   assign DE        = w_run & w_sel_sync[3];
   assign hblank    = w_sel_sync[2];
   assign vblank    = w_sel_sync[1];
   assign vdp_int_n = w_run ? w_sel_sync[0] : 1'b1;
   assign ram_bank  = w_bank_arr[active_q];
   assign vram_addr = w_clear ? cnt_q[VRAM_AW-1:0] : w_vaddr_arr[active_q];
   assign vram_do   = w_clear ? 8'h00 : w_vdo_arr[active_q];
   assign vram_we   = w_clear ? {VRAM_BANKS{1'b1}} :
                      (w_run ? w_vwe_arr[active_q] : {VRAM_BANKS{1'b0}});
   assign active    = active_q;
   assign busy      = ~w_run;

   always_ff @(posedge clk21m or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_HOLD;
         active_q <= 2'd0;
         target_q <= 2'd0;
         cnt_q    <= '0;
         vblank_q <= 1'b0;
      end else begin
         vblank_q <= w_sel_sync[1];
         case (state_q)
            ST_RUN: begin
               if (w_req_valid && (typ_req != active_q)) begin
                  target_q <= typ_req;
                  state_q  <= ST_DRAIN;
                  cnt_q    <= '0;
               end else if (soft_reset) begin
                  target_q <= active_q;
                  state_q  <= ST_DRAIN;
                  cnt_q    <= '0;
               end
            end
            ST_DRAIN: begin
               if (w_vb_rise || (cnt_q == c_drain_last)) begin
                  active_q <= target_q;
                  state_q  <= ST_HOLD;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + c_one;
               end
            end
            ST_HOLD: begin
               if (cnt_q == c_hold_last) begin
                  cnt_q   <= '0;
                  state_q <= (CLEAR_VRAM != 0) ? ST_CLEAR : ST_RUN;
               end else begin
                  cnt_q <= cnt_q + c_one;
               end
            end
            ST_CLEAR: begin
               if (cnt_q == c_clear_last) begin
                  cnt_q   <= '0;
                  state_q <= ST_RUN;
               end else begin
                  cnt_q <= cnt_q + c_one;
               end
            end
            default: begin
               state_q <= ST_HOLD;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_msx_core_switch.sv
`default_nettype none
// Randomized scoreboard bench for msx_core_switch (2 cores, short hold/drain, 16-entry VRAM).
module tb_msx_core_switch;

   localparam int NC    = 2;
   localparam int VB    = 2;
   localparam int AW    = 4;
   localparam int HC    = 8;
   localparam int DT    = 32;
   localparam int W_LEN = HC + (1 << AW);

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_WIN   = 2;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [1:0]          typ_req;
   logic                soft_reset;
   logic                wr_n;
   logic [NC-1:0]       core_wr_n;
   logic [NC-1:0]       core_reset;
   logic [8*NC-1:0]     core_d_to_cpu;
   logic [NC-1:0]       core_busrq;
   logic [24*NC-1:0]    core_rgb;
   logic [6*NC-1:0]     core_sync;
   logic [6*NC-1:0]     sync_rand;
   logic [NC-1:0]       vb_ctl;
   logic [8*NC-1:0]     core_ram_bank;
   logic [AW*NC-1:0]    core_vram_addr;
   logic [8*NC-1:0]     core_vram_do;
   logic [VB*NC-1:0]    core_vram_we;
   logic [7:0]          d_to_cpu;
   logic                dataBusRQ;
   logic [7:0]          R, G, B;
   logic                HS, VS, DE, hblank, vblank, vdp_int_n;
   logic [7:0]          ram_bank;
   logic [AW-1:0]       vram_addr;
   logic [7:0]          vram_do;
   logic [VB-1:0]       vram_we;
   logic [1:0]          active;
   logic                busy;

   msx_core_switch #(
      .NUM_CORES(NC), .VRAM_BANKS(VB), .VRAM_AW(AW),
      .HOLD_CYCLES(HC), .DRAIN_TIMEOUT(DT), .CLEAR_VRAM(1)
   ) dut (
      .clk21m(clk), .reset_n(reset_n), .typ_req(typ_req), .soft_reset(soft_reset),
      .wr_n(wr_n), .core_wr_n(core_wr_n), .core_reset(core_reset),
      .core_d_to_cpu(core_d_to_cpu), .core_busrq(core_busrq), .core_rgb(core_rgb),
      .core_sync(core_sync), .core_ram_bank(core_ram_bank),
      .core_vram_addr(core_vram_addr), .core_vram_do(core_vram_do),
      .core_vram_we(core_vram_we), .d_to_cpu(d_to_cpu), .dataBusRQ(dataBusRQ),
      .R(R), .G(G), .B(B), .HS(HS), .VS(VS), .DE(DE), .hblank(hblank),
      .vblank(vblank), .vdp_int_n(vdp_int_n), .ram_bank(ram_bank),
      .vram_addr(vram_addr), .vram_do(vram_do), .vram_we(vram_we),
      .active(active), .busy(busy)
   );

   always #5 clk = ~clk;

   // vblank of each core is steered directly so edges land exactly where wanted.
   always_comb begin
      core_sync = sync_rand;
      for (int i = 0; i < NC; i++) core_sync[6*i+1] = vb_ctl[i];
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_mode;
   int         m_k;
   logic [1:0] m_active;
   logic [1:0] m_target;
   logic       m_vbp;
   logic       m_vbn;
   logic [AW-1:0] q_clear[$];
   logic [1:0]    q_done[$];

   task automatic push_window(input logic [1:0] a);
      for (int i = 0; i < (1 << AW); i++) q_clear.push_back(AW'(i));
      q_done.push_back(a);
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_mode = M_WIN; m_k = 0; m_active = 2'd0; m_target = 2'd0; m_vbp = 1'b0;
         q_clear.delete(); q_done.delete();
         push_window(2'd0);
      end else begin
         m_vbn = core_sync[6*int'(m_active)+1];
         case (m_mode)
            M_RUN: begin
               if (int'(typ_req) < NC && typ_req != m_active) begin
                  m_target = typ_req; m_mode = M_DRAIN; m_k = 0;
               end else if (soft_reset) begin
                  m_target = m_active; m_mode = M_DRAIN; m_k = 0;
               end
            end
            M_DRAIN: begin
               if ((m_vbn && !m_vbp) || m_k == DT - 1) begin
                  m_active = m_target; m_mode = M_WIN; m_k = 0;
                  push_window(m_target);
               end else m_k++;
            end
            default: begin
               if (m_k == W_LEN - 1) m_mode = M_RUN;
               else m_k++;
            end
         endcase
         m_vbp = m_vbn;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic prev_busy = 1'b1;
   always @(negedge clk) begin : p_check
      int a;
      logic run, clr;
      logic [NC-1:0] e_rst, e_wrn;
      logic [VB-1:0] e_we;
      logic [5:0] s;
      logic [AW-1:0] e_addr;
      logic [1:0] e_act;
      if (chk_en) begin
         a   = int'(m_active);
         run = (m_mode == M_RUN);
         clr = (m_mode == M_WIN) && (m_k >= HC);
         s   = core_sync[6*a +: 6];
         e_rst = '1; e_wrn = '1;
         if (run) begin e_rst[a] = 1'b0; e_wrn[a] = wr_n; end
         e_we = clr ? {VB{1'b1}} : (run ? core_vram_we[VB*a +: VB] : {VB{1'b0}});
         chk("busy", 64'(busy), 64'(!run));
         chk("active", 64'(active), 64'(m_active));
         chk("core_reset", 64'(core_reset), 64'(e_rst));
         chk("core_wr_n", 64'(core_wr_n), 64'(e_wrn));
         chk("d_to_cpu", 64'(d_to_cpu), 64'(run ? core_d_to_cpu[8*a +: 8] : 8'hFF));
         chk("busrq", 64'(dataBusRQ), 64'(run & core_busrq[a]));
         chk("rgb", 64'({R, G, B}), 64'(run ? core_rgb[24*a +: 24] : 24'h0));
         chk("sync", 64'({HS, VS, DE, hblank, vblank, vdp_int_n}),
             64'({s[5], s[4], run & s[3], s[2], s[1], run ? s[0] : 1'b1}));
         chk("vram_we", 64'(vram_we), 64'(e_we));
         if (run) begin
            chk("ram_bank", 64'(ram_bank), 64'(core_ram_bank[8*a +: 8]));
            chk("vram_addr_run", 64'(vram_addr), 64'(core_vram_addr[AW*a +: AW]));
            chk("vram_do_run", 64'(vram_do), 64'(core_vram_do[8*a +: 8]));
         end
         if (busy && vram_we != '0) begin
            if (q_clear.size() == 0) chk("clear_unexpected", 64'(vram_we), 64'd0);
            else begin
               e_addr = q_clear.pop_front();
               chk("clear_addr", 64'(vram_addr), 64'(e_addr));
               chk("clear_data", 64'(vram_do), 64'd0);
               chk("clear_we", 64'(vram_we), 64'(2'b11));
            end
         end
         if (!busy && prev_busy) begin
            chk("clear_left", 64'(q_clear.size()), 64'd0);
            if (q_done.size() == 0) chk("done_unexpected", 64'(active), 64'hDEAD);
            else begin
               e_act = q_done.pop_front();
               chk("done_active", 64'(active), 64'(e_act));
            end
         end
         prev_busy = busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic rand_cores();
      core_d_to_cpu  = (8*NC)'({$urandom, $urandom});
      core_busrq     = NC'($urandom);
      core_rgb       = (24*NC)'({$urandom, $urandom});
      sync_rand      = (6*NC)'($urandom);
      core_ram_bank  = (8*NC)'($urandom);
      core_vram_addr = (AW*NC)'($urandom);
      core_vram_do   = (8*NC)'($urandom);
      core_vram_we   = (VB*NC)'($urandom);
      wr_n           = 1'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      rand_cores();
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin step(); n++; end
      chk(nm, 64'(busy), 64'd0);
   endtask

   task automatic steps_to_clear(output int n);
      n = 0;
      do begin step(); n++; end while (vram_we !== 2'b11 && n < 300);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      typ_req = 2'd0; soft_reset = 1'b0; vb_ctl = '0;
      rand_cores();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) step();
      chk("reset_busy", 64'(busy), 64'd1);
      chk("reset_core_reset", 64'(core_reset), 64'(2'b11));

      // power-up: hold then clear, then core 0 runs
      reset_n = 1'b1;
      n = 0;
      while (busy && n < 100) begin step(); n++; end
      chk("powerup_busy_len", 64'(n), 64'(W_LEN));
      chk("powerup_core_reset", 64'(core_reset), 64'(2'b10));

      // switch to core 1 on core 0 vblank
      typ_req = 2'd1;
      repeat (5) step();
      vb_ctl[0] = 1'b1;
      steps_to_clear(n);
      chk("vblank_hold_to_clear", 64'(n), 64'(1 + HC));
      vb_ctl[0] = 1'b0;
      wait_idle("switch_idle");
      chk("switch_active", 64'(active), 64'd1);
      chk("switch_core_reset", 64'(core_reset), 64'(2'b01));

      // timeout back to core 0 with no vblank
      typ_req = 2'd0;
      steps_to_clear(n);
      chk("timeout_len", 64'(n), 64'(1 + DT + HC));
      wait_idle("timeout_idle");
      chk("timeout_active", 64'(active), 64'd0);

      // invalid requests are ignored
      typ_req = 2'd3;
      repeat (10) begin step(); chk("invalid3_busy", 64'(busy), 64'd0); end
      typ_req = 2'd2;
      repeat (10) begin step(); chk("invalid2_busy", 64'(busy), 64'd0); end
      chk("invalid_active", 64'(active), 64'd0);

      // re-request toggling during hold
      typ_req = 2'd1;
      step();
      vb_ctl[0] = 1'b1;
      step();
      vb_ctl[0] = 1'b0;
      wr_n = 1'b0;
      #1 chk("hold_wr_gate", 64'(core_wr_n), 64'(2'b11));
      typ_req = 2'd0; step(); step();
      typ_req = 2'd1; step(); step();
      typ_req = 2'd0;
      wait_idle("rereq_idle");
      chk("rereq_active", 64'(active), 64'd1);
      step();
      chk("rereq_new_drain", 64'(busy), 64'd1);
      wait_idle("rereq2_idle");
      chk("rereq2_active", 64'(active), 64'd0);

      // soft reset restarts the current core
      soft_reset = 1'b1; step(); soft_reset = 1'b0;
      chk("soft_busy", 64'(busy), 64'd1);
      wait_idle("soft_idle");
      chk("soft_active", 64'(active), 64'd0);

      // reset in mid-switch abandons it
      typ_req = 2'd1;
      repeat (3) step();
      reset_n = 1'b0; typ_req = 2'd0;
      step(); step();
      chk("midreset_active", 64'(active), 64'd0);
      reset_n = 1'b1;
      wait_idle("midreset_idle");
      chk("midreset_final", 64'(active), 64'd0);

      // randomized traffic
      repeat (1500) begin
         step();
         if ($urandom_range(0, 39) == 0) typ_req = 2'($urandom);
         soft_reset = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < NC; i++)
            if ($urandom_range(0, 7) == 0) vb_ctl[i] = ~vb_ctl[i];
         if ($urandom_range(0, 499) == 0) begin
            reset_n = 1'b0; step(); step(); reset_n = 1'b1;
         end
      end
      soft_reset = 1'b0;
      wait_idle("final_idle");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
